// File: rtl/note_envelope_pkg.sv
// Shared widths, limits and envelope state encoding for the note envelope stage.
package note_envelope_pkg;

  localparam int GAIN_W   = 8;
  localparam int SAMPLE_W = 16;
  localparam int PROD_W   = SAMPLE_W + GAIN_W + 1;

  localparam logic [GAIN_W-1:0] GAIN_MAX = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/note_envelope_if.sv
// Sample stream and note event bundle between the chord mixer and the envelope stage.
interface note_envelope_if;
  import note_envelope_pkg::*;

  logic                play;
  logic                note_on;
  logic                note_off;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_in_valid;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_out_valid;
  logic [GAIN_W-1:0]   gain;

  modport master (
    output play, note_on, note_off, sample_in, sample_in_valid,
    input  sample_out, sample_out_valid, gain
  );

  modport slave (
    input  play, note_on, note_off, sample_in, sample_in_valid,
    output sample_out, sample_out_valid, gain
  );

endinterface

// File: rtl/note_envelope_gen.sv
// Envelope generator: ADSR state machine and gain register.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | silent, gain 0, waiting for note_on
// ST_ATTACK  | gain ramps up by ATTACK_STEP, saturates at 255
// ST_DECAY   | gain ramps down by DECAY_STEP to SUSTAIN_LEVEL
// ST_SUSTAIN | gain held at SUSTAIN_LEVEL
// ST_RELEASE | gain ramps down by RELEASE_STEP to 0
module note_envelope_gen
  import note_envelope_pkg::*;
#(
  parameter int unsigned ATTACK_STEP   = 16,
  parameter int unsigned DECAY_STEP    = 1,
  parameter int unsigned SUSTAIN_LEVEL = 192,
  parameter int unsigned RELEASE_STEP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              note_on,
  input  logic              note_off,
  input  logic              step,
  output logic [GAIN_W-1:0] gain
);

  localparam logic        [GAIN_W:0]   ATK_INC = (GAIN_W+1)'(ATTACK_STEP);
  localparam logic signed [GAIN_W+1:0] DEC_S   = (GAIN_W+2)'(DECAY_STEP);
  localparam logic signed [GAIN_W+1:0] REL_S   = (GAIN_W+2)'(RELEASE_STEP);
  localparam logic signed [GAIN_W+1:0] SUS_S   = (GAIN_W+2)'(SUSTAIN_LEVEL);
  localparam logic signed [GAIN_W+1:0] ZERO_S  = '0;
  localparam logic        [GAIN_W-1:0] SUS_LVL = GAIN_W'(SUSTAIN_LEVEL);

  env_state_t               state;
  env_state_t               evt_state;
  logic [GAIN_W:0]          gain_up;
  logic signed [GAIN_W+1:0] gain_dec;
  logic signed [GAIN_W+1:0] gain_rel;

  // Resolve note events first so a same-cycle step uses the new state; note_on wins.
  always_comb begin
    evt_state = state;
    if (note_on) begin
      evt_state = ST_ATTACK;
    end else if (note_off && (state == ST_ATTACK || state == ST_DECAY ||
                              state == ST_SUSTAIN)) begin
      evt_state = ST_RELEASE;
    end
  end

  assign gain_up  = {1'b0, gain} + ATK_INC;
  assign gain_dec = $signed({2'b00, gain}) - DEC_S;
  assign gain_rel = $signed({2'b00, gain}) - REL_S;

  // State and gain advance only while playing; gain steps only on sample strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      gain  <= '0;
    end else if (play) begin
      state <= evt_state;
      if (step) begin
        unique case (evt_state)
          ST_ATTACK: begin
            if (gain_up >= {1'b0, GAIN_MAX}) begin
              gain  <= GAIN_MAX;
              state <= ST_DECAY;
            end else begin
              gain <= gain_up[GAIN_W-1:0];
            end
          end
          ST_DECAY: begin
            if (gain_dec <= SUS_S) begin
              gain  <= SUS_LVL;
              state <= ST_SUSTAIN;
            end else begin
              gain <= gain_dec[GAIN_W-1:0];
            end
          end
          ST_RELEASE: begin
            if (gain_rel <= ZERO_S) begin
              gain  <= '0;
              state <= ST_IDLE;
            end else begin
              gain <= gain_rel[GAIN_W-1:0];
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/note_envelope.sv
// Note envelope stage: scales the mixed sample stream by the ADSR gain, one cycle latency.
module note_envelope
  import note_envelope_pkg::*;
#(
  parameter int unsigned ATTACK_STEP   = 16,
  parameter int unsigned DECAY_STEP    = 1,
  parameter int unsigned SUSTAIN_LEVEL = 192,
  parameter int unsigned RELEASE_STEP  = 2
) (
  input logic           clk,
  input logic           reset,
  note_envelope_if.slave bus
);

  logic [GAIN_W-1:0]          gain;
  logic signed [PROD_W-1:0]   prod;
  logic signed [SAMPLE_W-1:0] prod_scaled;

  note_envelope_gen #(
    .ATTACK_STEP   (ATTACK_STEP),
    .DECAY_STEP    (DECAY_STEP),
    .SUSTAIN_LEVEL (SUSTAIN_LEVEL),
    .RELEASE_STEP  (RELEASE_STEP)
  ) u_gen (
    .clk      (clk),
    .reset    (reset),
    .play     (bus.play),
    .note_on  (bus.note_on),
    .note_off (bus.note_off),
    .step     (bus.sample_in_valid),
    .gain     (gain)
  );

  // Gain is the pre-update register value, so each sample uses the gain in force when it arrived.
  assign prod        = PROD_W'($signed(bus.sample_in)) * PROD_W'($signed({1'b0, gain}));
  assign prod_scaled = SAMPLE_W'(prod >>> GAIN_W);
  assign bus.gain    = gain;

  // Output register: capture the scaled sample on each strobe, hold it otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sample_out       <= '0;
      bus.sample_out_valid <= 1'b0;
    end else begin
      bus.sample_out_valid <= bus.sample_in_valid;
      if (bus.sample_in_valid) begin
        bus.sample_out <= prod_scaled;
      end
    end
  end

endmodule
